// File: rtl/ram_bus_arbiter.sv
// ============================================================================
// Module      : ram_bus_arbiter
// Description : Round-robin arbiter/sequencer sharing one 8-bit RAM bus
//               between two REQ/ACK requesters, with read turnaround.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_bus_arbiter #(
  parameter logic [7:0] PARK_ADDR = 8'hFF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_A,
  input  logic       WE_A,
  input  logic [7:0] ADDR_A,
  input  logic [7:0] WDATA_A,
  input  logic       REQ_B,
  input  logic       WE_B,
  input  logic [7:0] ADDR_B,
  input  logic [7:0] WDATA_B,
  output logic       ACK_A,
  output logic       ACK_B,
  output logic [7:0] RDATA,
  output logic       BUSY,
  output logic [7:0] BUS_ADDR,
  output logic       BUS_WE,
  inout  wire  [7:0] BUS_DATA
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_DATA = 3'd3,
    S_TURN    = 3'd4
  } state_t;

  state_t     r_state;
  logic       r_last_b;
  logic       r_grant_b;
  logic [7:0] r_wdata;
  logic       r_ack_a;
  logic       r_ack_b;
  logic [7:0] r_rdata;
  logic [7:0] r_bus_addr;
  logic       r_bus_we;
  logic       r_drive;
  logic       r_busy;

  logic w_elig_a;
  logic w_elig_b;
  logic w_pick_b;
  logic w_sel_we;

  // A requester whose ACK is high this cycle is finishing, not re-requesting.
  assign w_elig_a = REQ_A & ~r_ack_a;
  assign w_elig_b = REQ_B & ~r_ack_b;
  assign w_pick_b = w_elig_b & (~w_elig_a | ~r_last_b);
  assign w_sel_we = w_pick_b ? WE_B : WE_A;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_last_b   <= 1'b1;
      r_grant_b  <= 1'b0;
      r_wdata    <= 8'h00;
      r_ack_a    <= 1'b0;
      r_ack_b    <= 1'b0;
      r_rdata    <= 8'h00;
      r_bus_addr <= PARK_ADDR;
      r_bus_we   <= 1'b0;
      r_drive    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_elig_a | w_elig_b) begin
            r_last_b   <= w_pick_b;
            r_grant_b  <= w_pick_b;
            r_wdata    <= w_pick_b ? WDATA_B : WDATA_A;
            r_bus_addr <= w_pick_b ? ADDR_B : ADDR_A;
            r_busy     <= 1'b1;
            if (w_sel_we) begin
              r_state  <= S_WRITE;
              r_bus_we <= 1'b1;
              r_drive  <= 1'b1;
            end else begin
              r_state  <= S_RD_ADDR;
            end
          end
        end
        S_WRITE: begin
          r_ack_a    <= ~r_grant_b;
          r_ack_b    <= r_grant_b;
          r_state    <= S_IDLE;
          r_bus_addr <= PARK_ADDR;
          r_bus_we   <= 1'b0;
          r_drive    <= 1'b0;
          r_busy     <= 1'b0;
        end
        S_RD_ADDR: begin
          r_state <= S_RD_DATA;
        end
        S_RD_DATA: begin
          r_rdata    <= BUS_DATA;
          r_ack_a    <= ~r_grant_b;
          r_ack_b    <= r_grant_b;
          r_state    <= S_TURN;
          r_bus_addr <= PARK_ADDR;
        end
        S_TURN: begin
          // RAM output enable is registered, so it still drives here.
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_bus_addr <= PARK_ADDR;
          r_bus_we   <= 1'b0;
          r_drive    <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign ACK_A    = r_ack_a;
  assign ACK_B    = r_ack_b;
  assign RDATA    = r_rdata;
  assign BUSY     = r_busy;
  assign BUS_ADDR = r_bus_addr;
  assign BUS_WE   = r_bus_we;
  assign BUS_DATA = r_drive ? r_wdata : 8'hzz;

endmodule

`default_nettype wire

// File: tb/tb_ram_bus_arbiter.sv
// ============================================================================
// Module      : tb_ram_bus_arbiter
// Description : Scoreboard bench for ram_bus_arbiter with a registered-read
//               tristate RAM model occupying addresses 8'h00-8'h7F.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_bus_arbiter;

  localparam logic [7:0] c_park = 8'hFF;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       REQ_A = 1'b0, WE_A = 1'b0, REQ_B = 1'b0, WE_B = 1'b0;
  logic [7:0] ADDR_A = 8'h00, WDATA_A = 8'h00, ADDR_B = 8'h00, WDATA_B = 8'h00;
  logic       ACK_A, ACK_B, BUSY, BUS_WE;
  logic [7:0] RDATA, BUS_ADDR;
  wire  [7:0] BUS_DATA;

  ram_bus_arbiter #(.PARK_ADDR(c_park)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_A(REQ_A), .WE_A(WE_A), .ADDR_A(ADDR_A), .WDATA_A(WDATA_A),
    .REQ_B(REQ_B), .WE_B(WE_B), .ADDR_B(ADDR_B), .WDATA_B(WDATA_B),
    .ACK_A(ACK_A), .ACK_B(ACK_B), .RDATA(RDATA), .BUSY(BUSY),
    .BUS_ADDR(BUS_ADDR), .BUS_WE(BUS_WE), .BUS_DATA(BUS_DATA)
  );

  always #5 CLK = ~CLK;

  // RAM model: writes on the edge, registered read data and output enable
  logic [7:0] mem [0:127];
  logic       ram_oe = 1'b0;
  logic [7:0] ram_dout = 8'h00;
  assign BUS_DATA = ram_oe ? ram_dout : 8'hzz;

  always @(posedge CLK) begin
    if (BUS_WE && BUS_ADDR < 8'h80) mem[BUS_ADDR[6:0]] <= BUS_DATA;
    ram_oe   <= !BUS_WE && (BUS_ADDR < 8'h80);
    ram_dout <= mem[BUS_ADDR[6:0]];
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit         is_b;
    bit         chk_rd;
    logic [7:0] rdata;
    int         ack_cyc;
  } exp_t;
  exp_t sb_q[$];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t cyc=%0d)", tag, got, exp, $time, cyc);
    end
  endtask

  bit mon_en = 1'b0;
  bit prev_a = 1'b0, prev_b = 1'b0;
  int we_cnt = 0;

  always @(negedge CLK) begin
    exp_t e;
    if (mon_en) begin
      if (ram_oe) chk("bus_rd", BUS_DATA, ram_dout);
      else if (!BUS_WE) chk("bus_float", (BUS_DATA === 8'hzz) || (BUS_DATA === 8'h00), 1);
      chk("ack_overlap", ACK_A & ACK_B, 0);
      chk("ack_a_pulse", ACK_A & prev_a, 0);
      chk("ack_b_pulse", ACK_B & prev_b, 0);
      if (BUS_WE) we_cnt++;
      if (ACK_A || ACK_B) begin
        if (sb_q.size() == 0) chk("ack_unexpected", 1, 0);
        else begin
          e = sb_q.pop_front();
          chk("ack_who", ACK_B, e.is_b);
          if (e.chk_rd) chk("rdata", RDATA, e.rdata);
          if (e.ack_cyc >= 0) chk("ack_lat", cyc, e.ack_cyc);
        end
      end
    end
    prev_a = ACK_A;
    prev_b = ACK_B;
  end

  // One transaction; lat is the ACK cycle offset from the raise cycle, -1 = unchecked
  task automatic xact(input bit is_b, input bit we, input logic [7:0] addr,
                      input logic [7:0] wd, input logic [7:0] rd,
                      input bit chk_rd, input int lat);
    exp_t e;
    int   n;
    bit   got;
    @(negedge CLK);
    e.is_b = is_b; e.chk_rd = chk_rd; e.rdata = rd;
    e.ack_cyc = (lat < 0) ? -1 : cyc + lat;
    sb_q.push_back(e);
    if (is_b) begin WE_B = we; ADDR_B = addr; WDATA_B = wd; REQ_B = 1'b1; end
    else      begin WE_A = we; ADDR_A = addr; WDATA_A = wd; REQ_A = 1'b1; end
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge CLK);
      n++;
      got = is_b ? ACK_B : ACK_A;
    end
    chk("ack_seen", got, 1);
    if (got && !we) begin
      chk("turn_addr", BUS_ADDR, c_park);
      chk("turn_we", BUS_WE, 0);
    end
    if (is_b) REQ_B = 1'b0; else REQ_A = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0, c, na, nb, n;
    exp_t e;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'hA5;

    repeat (3) @(negedge CLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_addr", BUS_ADDR, c_park);
    chk("rst_we", BUS_WE, 0);
    chk("rst_ack_a", ACK_A, 0);
    chk("rst_ack_b", ACK_B, 0);
    chk("rst_rdata", RDATA, 0);
    RESET = 1'b0;
    mon_en = 1'b1;

    // A write then read back
    we0 = we_cnt;
    xact(1'b0, 1'b1, 8'h10, 8'h5A, 8'h00, 1'b0, 2);
    chk("we_cycles", we_cnt - we0, 1);
    chk("mem10", mem[8'h10], 8'h5A);
    xact(1'b0, 1'b0, 8'h10, 8'h00, 8'h5A, 1'b1, 3);

    // Both requesters held: strict alternation starting with A
    do_reset();
    @(negedge CLK);
    c = cyc;
    WE_A = 1'b1; ADDR_A = 8'h30; WDATA_A = 8'hC0; REQ_A = 1'b1;
    WE_B = 1'b1; ADDR_B = 8'h40; WDATA_B = 8'hD0; REQ_B = 1'b1;
    for (int k = 0; k < 6; k++) begin
      e.is_b = k[0]; e.chk_rd = 1'b0; e.rdata = 8'h00; e.ack_cyc = c + 2 + 2 * k;
      sb_q.push_back(e);
    end
    na = 0; nb = 0; n = 0;
    while ((na < 3 || nb < 3) && n < 40) begin
      @(negedge CLK);
      n++;
      if (ACK_A) begin
        na++;
        if (na < 3) begin ADDR_A = 8'h30 + 8'(na); WDATA_A = 8'hC0 + 8'(na); end
        else REQ_A = 1'b0;
      end
      if (ACK_B) begin
        nb++;
        if (nb < 3) begin ADDR_B = 8'h40 + 8'(nb); WDATA_B = 8'hD0 + 8'(nb); end
        else REQ_B = 1'b0;
      end
    end
    chk("alt_done", (na == 3) && (nb == 3), 1);
    REQ_A = 1'b0; REQ_B = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("alt_mem_a", mem[8'h30 + k], 8'hC0 + 8'(k));
      chk("alt_mem_b", mem[8'h40 + k], 8'hD0 + 8'(k));
    end

    // B read of 8'h20 followed by A write of 8'h20 one cycle later
    fork
      xact(1'b1, 1'b0, 8'h20, 8'h00, 8'h20 ^ 8'hA5, 1'b1, 3);
      begin
        @(negedge CLK);
        xact(1'b0, 1'b1, 8'h20, 8'h3C, 8'h00, 1'b0, 5);
      end
    join
    chk("mem20", mem[8'h20], 8'h3C);

    // Reset during RD_DATA of a B read
    @(negedge CLK);
    WE_B = 1'b0; ADDR_B = 8'h10; REQ_B = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rd_data_busy", BUSY, 1);
    RESET = 1'b1; REQ_B = 1'b0;
    @(negedge CLK);
    chk("mid_busy", BUSY, 0);
    chk("mid_ack_b", ACK_B, 0);
    chk("mid_rdata", RDATA, 0);
    chk("mid_addr", BUS_ADDR, c_park);
    chk("mid_we", BUS_WE, 0);
    RESET = 1'b0;
    repeat (5) @(negedge CLK);

    // B read outside the RAM window: same timing, ACK still issued
    xact(1'b1, 1'b0, 8'h90, 8'h00, 8'h00, 1'b0, 3);
    repeat (4) @(negedge CLK);

    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
